vdp_command_lrmm_walker: RTL and testbench

//  Source/destination coordinate generator for the LRMM (Logical Rotate vraM to vraM) command.

---
 rtl/vdp_command_lrmm_walker_if.sv | 22 ++
 rtl/vdp_command_lrmm_walker.sv | 135 +++++++++++++
 tb/tb_vdp_command_lrmm_walker.sv | 112 +++++++++++
 3 files changed

// File: rtl/vdp_command_lrmm_walker_if.sv
// vdp_command_lrmm_walker_if: command/parameter inputs and coordinate output stream of the LRMM walker
//   start/abort        command pulse and cancel
//   sx,sy,dx,dy        source and destination start coordinates
//   nx,ny              rectangle size (0 = 512 / 1024)
//   vx,vy,dix,diy      Q8.8 step vector and destination directions
//   out_*              coordinate pair stream, valid/ready handshake
//   busy               walk in progress
interface vdp_command_lrmm_walker_if;
   logic        start, abort;
   logic [8:0]  sx, dx;
   logic [9:0]  sy, dy, nx, ny;
   logic [15:0] vx, vy;
   logic        dix, diy;
   logic        out_valid, out_ready;
   logic [8:0]  out_src_x, out_dst_x;
   logic [9:0]  out_src_y, out_dst_y;
   logic        out_clip, out_last, busy;
   modport master (output start, abort, sx, sy, dx, dy, nx, ny, vx, vy, dix, diy, out_ready,
                   input out_valid, out_src_x, out_src_y, out_dst_x, out_dst_y, out_clip, out_last, busy);
   modport slave  (input start, abort, sx, sy, dx, dy, nx, ny, vx, vy, dix, diy, out_ready,
                   output out_valid, out_src_x, out_src_y, out_dst_x, out_dst_y, out_clip, out_last, busy);
endinterface

// File: rtl/vdp_command_lrmm_walker.sv
// vdp_command_lrmm_walker: LRMM source/destination coordinate generator walking an NX x NY rectangle
//   clk_i    system clock
//   reset_i  synchronous active-high reset
//   bus      slave side of vdp_command_lrmm_walker_if (command inputs, pair stream, busy)
module vdp_command_lrmm_walker #(
   parameter int FRAC_BITS = 8,
   parameter int X_LIMIT   = 512,
   parameter int Y_LIMIT   = 1024
) (
   input logic clk_i,
   input logic reset_i,
   vdp_command_lrmm_walker_if.slave bus
);
   typedef enum logic [1:0] {IDLE, INIT, EMIT, LINE} state_t;
   state_t      state_q, state_d;
   logic [20:0] rx_q, rx_d, ry_q, ry_d, px_q, px_d, py_q, py_d, vx_e, vy_e;
   logic [15:0] vx_q, vy_q;
   logic [9:0]  nx_q, cnt_x_q, cnt_x_d;
   logic [10:0] cnt_y_q, cnt_y_d;
   logic [8:0]  dx_q, cur_dx_q, cur_dx_d, src_x_q, dst_x_q;
   logic [9:0]  cur_dy_q, cur_dy_d, src_y_q, dst_y_q;
   logic [19:0] ix, iy;
   logic        dix_q, diy_q, valid_q, valid_d, clip_q, last_q, load, hs;
   assign vx_e = {{5{vx_q[15]}}, vx_q};
   assign vy_e = {{5{vy_q[15]}}, vy_q};
   assign hs   = valid_q & bus.out_ready;
   always_comb begin
      state_d  = state_q;
      rx_d     = rx_q;
      ry_d     = ry_q;
      px_d     = px_q;
      py_d     = py_q;
      cnt_x_d  = cnt_x_q;
      cnt_y_d  = cnt_y_q;
      cur_dx_d = cur_dx_q;
      cur_dy_d = cur_dy_q;
      valid_d  = valid_q;
      load     = 1'b0;
      unique case (state_q)
         IDLE: if (bus.start) begin
            rx_d     = 21'(bus.sx) << FRAC_BITS;
            ry_d     = 21'(bus.sy) << FRAC_BITS;
            px_d     = rx_d;
            py_d     = ry_d;
            cnt_x_d  = bus.nx == '0 ? 10'd512 : bus.nx;
            cnt_y_d  = {bus.ny == '0, bus.ny};
            cur_dx_d = bus.dx;
            cur_dy_d = bus.dy;
            state_d  = INIT;
         end
         INIT, LINE: begin
            load    = 1'b1;
            valid_d = 1'b1;
            state_d = EMIT;
         end
         EMIT: if (hs) begin
            if (last_q) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end else if (cnt_x_q > 10'd1) begin
               // next pixel goes straight out so a ready consumer sees one pair per cycle
               px_d     = px_q + vx_e;
               py_d     = py_q + vy_e;
               cur_dx_d = dix_q ? cur_dx_q - 9'd1 : cur_dx_q + 9'd1;
               cnt_x_d  = cnt_x_q - 10'd1;
               load     = 1'b1;
            end else begin
               // row step is the step vector rotated by +90 degrees
               rx_d     = rx_q - vy_e;
               ry_d     = ry_q + vx_e;
               px_d     = rx_d;
               py_d     = ry_d;
               cur_dx_d = dx_q;
               cur_dy_d = diy_q ? cur_dy_q - 10'd1 : cur_dy_q + 10'd1;
               cnt_x_d  = nx_q;
               cnt_y_d  = cnt_y_q - 11'd1;
               valid_d  = 1'b0;
               state_d  = LINE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (bus.abort) begin
         valid_d = 1'b0;
         state_d = IDLE;
      end
      // low bits of the integer part equal the floor even for negative accumulators
      ix = px_d[19:0] >> FRAC_BITS;
      iy = py_d[19:0] >> FRAC_BITS;
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         {rx_q, ry_q, px_q, py_q} <= '0;
         {vx_q, vy_q, nx_q, dx_q, dix_q, diy_q} <= '0;
         {cnt_x_q, cnt_y_q, cur_dx_q, cur_dy_q} <= '0;
         {valid_q, src_x_q, src_y_q, dst_x_q, dst_y_q, clip_q, last_q} <= '0;
      end else begin
         state_q  <= state_d;
         rx_q     <= rx_d;
         ry_q     <= ry_d;
         px_q     <= px_d;
         py_q     <= py_d;
         cnt_x_q  <= cnt_x_d;
         cnt_y_q  <= cnt_y_d;
         cur_dx_q <= cur_dx_d;
         cur_dy_q <= cur_dy_d;
         valid_q  <= valid_d;
         if (state_q == IDLE && bus.start && !bus.abort) begin
            vx_q  <= bus.vx;
            vy_q  <= bus.vy;
            dx_q  <= bus.dx;
            nx_q  <= bus.nx == '0 ? 10'd512 : bus.nx;
            dix_q <= bus.dix;
            diy_q <= bus.diy;
         end
         if (load) begin
            src_x_q <= ix[8:0];
            src_y_q <= iy[9:0];
            dst_x_q <= cur_dx_d;
            dst_y_q <= cur_dy_d;
            clip_q  <= px_d[20] | py_d[20] | (ix >= 20'(X_LIMIT)) | (iy >= 20'(Y_LIMIT));
            last_q  <= cnt_x_d == 10'd1 && cnt_y_d == 11'd1;
         end
      end
   end
   assign bus.out_valid = valid_q;
   assign bus.out_src_x = src_x_q;
   assign bus.out_src_y = src_y_q;
   assign bus.out_dst_x = dst_x_q;
   assign bus.out_dst_y = dst_y_q;
   assign bus.out_clip  = clip_q;
   assign bus.out_last  = last_q;
   assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_vdp_command_lrmm_walker.sv
// tb_vdp_command_lrmm_walker: randomized self-checking bench against a closed-form rectangle model
module tb_vdp_command_lrmm_walker;
   logic clk = 1'b0, reset = 1'b1;
   int   checks = 0, errors = 0;
   vdp_command_lrmm_walker_if bus ();
   vdp_command_lrmm_walker dut (.clk_i(clk), .reset_i(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [63:0] pk(logic [8:0] sx_, logic [9:0] sy_, logic [8:0] dx_, logic [9:0] dy_, logic c, logic l);
      return {24'h0, sx_, sy_, dx_, dy_, c, l};
   endfunction
   function automatic logic [63:0] cur();
      return pk(bus.out_src_x, bus.out_src_y, bus.out_dst_x, bus.out_dst_y, bus.out_clip, bus.out_last);
   endfunction
   // pixel (i,j) source = start + i*(vx,vy) + j*(-vy,vx), taken modulo 2^21
   task automatic run(input logic [8:0] sx, input logic [9:0] sy, input logic [8:0] dx, input logic [9:0] dy,
                      input logic [9:0] nx, input logic [9:0] ny, input logic [15:0] vx, input logic [15:0] vy,
                      input logic dix, input logic diy, input int pct, input int abort_at, input bit poke);
      int nxe = nx == 0 ? 512 : int'(nx);
      int nye = ny == 0 ? 1024 : int'(ny);
      int total = nxe * nye, hs = 0, lasts = 0;
      longint vxs = longint'($signed(vx)), vys = longint'($signed(vy));
      logic [63:0] exp_q[$];
      for (int j = 0; j < nye; j++)
         for (int i = 0; i < nxe; i++) begin
            longint ax = (longint'(sx) << 8) + longint'(i) * vxs - longint'(j) * vys;
            longint ay = (longint'(sy) << 8) + longint'(i) * vys + longint'(j) * vxs;
            logic [20:0] wx = ax[20:0], wy = ay[20:0];
            int fx = int'($signed(wx)) >>> 8, fy = int'($signed(wy)) >>> 8;
            logic [8:0] ox = dix ? dx - 9'(i) : dx + 9'(i);
            logic [9:0] oy = diy ? dy - 10'(j) : dy + 10'(j);
            exp_q.push_back(pk(fx[8:0], fy[9:0], ox, oy, fx < 0 || fx >= 512 || fy < 0 || fy >= 1024,
                               i == nxe - 1 && j == nye - 1));
         end
      bus.sx = sx; bus.sy = sy; bus.dx = dx; bus.dy = dy; bus.nx = nx; bus.ny = ny;
      bus.vx = vx; bus.vy = vy; bus.dix = dix; bus.diy = diy; bus.out_ready = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.sx = 9'h1ff ^ sx;
      bus.vx = ~vx;
      check("lat1_valid", 64'(bus.out_valid), 0);
      check("lat1_busy", 64'(bus.busy), 1);
      @(negedge clk);
      check("lat2_valid", 64'(bus.out_valid), 1);
      for (int cyc = 0; cyc < total * 8 + 50 && hs < total; cyc++) begin
         if (abort_at >= 0 && hs == abort_at) break;
         if (bus.out_valid) begin
            logic rdy = ($urandom % 100) < pct;
            check("pair", cur(), exp_q[0]);
            bus.out_ready = rdy;
            if (rdy) begin
               lasts += int'(bus.out_last);
               hs++;
               void'(exp_q.pop_front());
            end
         end else bus.out_ready = 1'($urandom);
         bus.start = poke && hs == 3;
         @(negedge clk);
      end
      bus.start = 1'b0;
      check("count", 64'(hs), 64'(abort_at >= 0 ? abort_at : total));
      if (abort_at >= 0) begin
         bus.abort = 1'b1;
         bus.out_ready = 1'b0;
         @(negedge clk);
         bus.abort = 1'b0;
      end else check("lasts", 64'(lasts), 1);
      check("end_valid", 64'(bus.out_valid), 0);
      check("end_busy", 64'(bus.busy), 0);
   endtask
   initial begin
      bus.start = 0; bus.abort = 0; bus.out_ready = 0;
      bus.sx = 0; bus.sy = 0; bus.dx = 0; bus.dy = 0; bus.nx = 0; bus.ny = 0;
      bus.vx = 0; bus.vy = 0; bus.dix = 0; bus.diy = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_valid", 64'(bus.out_valid), 0);
      check("rst_busy", 64'(bus.busy), 0);
      check("rst_outs", cur(), 0);
      run(0, 256, 0, 0, 16, 16, 16'h0100, 16'h0000, 0, 0, 100, -1, 0);
      run(100, 100, 0, 0, 4, 4, 16'h0000, 16'h0100, 0, 0, 100, -1, 0);
      run(10, 0, 0, 0, 4, 2, 16'h0080, 16'h0000, 0, 0, 100, -1, 0);
      run(2, 0, 0, 0, 4, 2, 16'hff00, 16'h0000, 0, 0, 100, -1, 0);
      run(7, 9, 33, 44, 1, 1, 16'h0123, 16'hfe00, 0, 0, 60, -1, 0);
      run(510, 1020, 510, 1022, 5, 4, 16'h0100, 16'h0100, 0, 0, 70, -1, 0);
      run(3, 5, 2, 1, 6, 5, 16'h0040, 16'hffc0, 1, 1, 50, -1, 1);
      run(100, 200, 0, 0, 0, 1, 16'h0100, 16'h0000, 0, 0, 100, -1, 0);
      for (int t = 0; t < 8; t++)
         run(9'($urandom), 10'($urandom), 9'($urandom), 10'($urandom), 10'($urandom_range(1, 12)),
             10'($urandom_range(1, 9)), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(30, 100)), -1, t[0]);
      run(20, 30, 0, 0, 4, 4, 16'h0100, 16'h0000, 0, 0, 100, 5, 0);
      run(300, 600, 1, 2, 3, 3, 16'h0000, 16'h0100, 0, 0, 100, -1, 0);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check("start_abort_busy", 64'(bus.busy), 0);
      check("start_abort_valid", 64'(bus.out_valid), 0);
      run(40, 50, 5, 6, 2, 2, 16'h0100, 16'h0000, 1, 0, 80, -1, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
